// File: rtl/reg_control_sequencer.sv
`timescale 1ns/1ps
// reg_control_sequencer: multi-cycle fetch/decode/exec/writeback control
// sequencer for the 8-bit, 4-register datapath.
//   clk, reset             : rising-edge clock, async active-high reset
//   instr_req/instr_valid  : fetch handshake with instruction memory
//   instr                  : instruction word (op=[7:6])
//   pc                     : current fetch address, wraps modulo 2^PC_WIDTH
//   read_reg1/2, write_reg : register file addresses (rs, rt, rd)
//   write                  : register file write enable, one pulse in WB
//   alu_op, wb_sel, imm    : ALU op (0 add/1 sub), writeback select, LI data
// All outputs are registered; next values are computed from next state + IR.
module reg_control_sequencer #(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned PC_RESET = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                instr_req,
  input  logic                instr_valid,
  input  logic [7:0]          instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [1:0]          read_reg1,
  output logic [1:0]          read_reg2,
  output logic [1:0]          write_reg,
  output logic                write,
  output logic                alu_op,
  output logic                wb_sel,
  output logic [7:0]          imm
);

  localparam logic [1:0] OP_LI  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_d;
  logic                instr_req_d;
  logic [1:0]          read_reg1_d, read_reg2_d, write_reg_d;
  logic                write_d, alu_op_d, wb_sel_d;
  logic [7:0]          imm_d;

  logic [1:0]          op;
  logic [PC_WIDTH-1:0] jmp_off;

  assign op      = ir_q[7:6];
  // Jump offset is a signed 6-bit field, extended to the pc width.
  assign jmp_off = PC_WIDTH'($signed(ir_q[5:0]));

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      ir_q      <= 8'd0;
      pc        <= PC_WIDTH'(PC_RESET);
      instr_req <= 1'b0;
      read_reg1 <= 2'd0;
      read_reg2 <= 2'd0;
      write_reg <= 2'd0;
      write     <= 1'b0;
      alu_op    <= 1'b0;
      wb_sel    <= 1'b0;
      imm       <= 8'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc        <= pc_d;
      instr_req <= instr_req_d;
      read_reg1 <= read_reg1_d;
      read_reg2 <= read_reg2_d;
      write_reg <= write_reg_d;
      write     <= write_d;
      alu_op    <= alu_op_d;
      wb_sel    <= wb_sel_d;
      imm       <= imm_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc_d        = pc;
    read_reg1_d = read_reg1;
    read_reg2_d = read_reg2;
    write_reg_d = write_reg;
    alu_op_d    = alu_op;
    wb_sel_d    = wb_sel;
    imm_d       = imm;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          pc_d    = pc + PC_WIDTH'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        read_reg1_d = ir_q[5:4];
        read_reg2_d = ir_q[3:2];
        // LI carries rd in the rs slot.
        write_reg_d = (op == OP_LI) ? ir_q[5:4] : ir_q[1:0];
        alu_op_d    = op[0];
        wb_sel_d    = (op == OP_LI);
        imm_d       = {4'b0000, ir_q[3:0]};
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_JMP) begin
          // Relative to the pc already advanced during fetch.
          pc_d    = pc + jmp_off;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_RESET;
    endcase

    instr_req_d = (state_d == S_FETCH);
    write_d     = (state_d == S_WB);
  end

endmodule

// File: doc/reg_control_sequencer.md
Name: reg_control_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit, 4-register datapath, sitting directly upstream of the register file. It fetches 8-bit instructions from instruction memory over a req/valid handshake and holds them in an instruction register. It decodes each instruction and drives the register file's read_reg1/read_reg2/write_reg/write ports, plus ALU-op and writeback-select controls. It owns the program counter, including relative jumps.

Parameters:
PC_WIDTH, 8, program counter width; pc wraps modulo 2^PC_WIDTH
PC_RESET, 0, pc value loaded on reset

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
instr_req  output  1  fetch request to instruction memory
instr_valid  input  1  instruction memory has instr valid this cycle
instr  input  8  instruction word
pc  output  PC_WIDTH  current fetch address
read_reg1  output  2  register file read address 1 (rs)
read_reg2  output  2  register file read address 2 (rt)
write_reg  output  2  register file write address (rd)
write  output  1  register file write enable, one-cycle pulse
alu_op  output  1  0 = add, 1 = subtract
wb_sel  output  1  0 = ALU result, 1 = immediate
imm  output  8  zero-extended immediate for LI

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: state=S_RESET, pc=PC_RESET, IR=0, all other outputs 0. Assertion takes effect immediately, including mid-instruction; a pending write pulse is dropped.
- Instruction encoding, op=instr[7:6]:
  - 00 ADD: rs=[5:4], rt=[3:2], rd=[1:0]
  - 01 SUB: same fields as ADD
  - 10 LI: rd=[5:4], imm=[3:0] zero-extended
  - 11 JMP: off=[5:0] sign-extended
- State machine, all outputs registered or decoded from state+IR:
  - S_RESET: instr_req=0. Goes to FETCH on the first clock edge after reset deasserts.
  - FETCH: instr_req=1. Stays in FETCH while instr_valid=0. On instr_valid=1: IR<=instr, pc<=pc+1 (wrap), go to DECODE.
  - DECODE: read_reg1<=rs, read_reg2<=rt, write_reg<=rd, alu_op<=op[0], wb_sel<=(op==10), imm<={4'b0,imm4}. Go to EXEC.
  - EXEC: for JMP, pc<=pc+sext(off) modulo 2^PC_WIDTH, relative to the already-incremented pc, then go to FETCH. Otherwise go to WB.
  - WB: write=1 for exactly this cycle with write_reg=rd. Go to FETCH.
- Output timing:
  - read_reg1/read_reg2/write_reg/alu_op/wb_sel/imm hold their values from DECODE until the next DECODE.
  - write is 0 in every state except WB.
- Latency, cycles after the instr_valid-accept edge to FETCH re-entry: ADD/SUB/LI = 3 (DECODE, EXEC, WB); JMP = 2.
- instr_valid is ignored outside FETCH. instr_req never asserts outside FETCH.
- pc wraps: 0xFF+1 -> 0x00. JMP off=0 is a no-op jump to the next sequential address.
- LI drives read_reg1=[5:4], read_reg2=[3:2]; the datapath ignores these because wb_sel=1.

Test Plan:
- Reset: assert reset mid-WB of ADD 0x1B -> write drops to 0 immediately; pc=0, state S_RESET. One edge after release, instr_req=1.
- ADD 0x1B at pc=0, instr_valid on the first FETCH cycle -> DECODE gives read_reg1=1, read_reg2=2, write_reg=3, alu_op=0, wb_sel=0; write=1 exactly in WB; pc=1.
- SUB 0x46 -> read_reg1=0, read_reg2=1, write_reg=2, alu_op=1; one write pulse.
- LI 0x9A -> write_reg=1, imm=0x0A, wb_sel=1, write pulses once.
- Fetch stall: hold instr_valid=0 for 5 cycles -> instr_req stays 1, pc and all register-file outputs unchanged, write=0; accepts on the 6th cycle.
- JMP 0xFE fetched at pc=5 -> pc=6 after fetch, pc=4 after EXEC, no write pulse. JMP 0x01 at pc=0xFF -> pc=0x01 after EXEC (wrap).
